// File: rtl/resource_arbiter_server_if.sv
// Req/grant bus between two requesting pipelines and the shared multiply resource.
// The master side drives requests and operands; the slave side (the server) answers.
interface resource_arbiter_server_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req_1;
    logic              req_2;
    logic [DATA_W-1:0] op_1;
    logic [DATA_W-1:0] op_2;
    logic              grant_1;
    logic              grant_2;
    logic              stall_1;
    logic              stall_2;
    logic [DATA_W-1:0] result;
    logic [1:0]        result_valid;
    logic              busy;

    modport master (
        output req_1, req_2, op_1, op_2,
        input  grant_1, grant_2, stall_1, stall_2, result, result_valid, busy
    );

    modport slave (
        input  req_1, req_2, op_1, op_2,
        output grant_1, grant_2, stall_1, stall_2, result, result_valid, busy
    );
endinterface

// File: rtl/resource_arbiter_server.sv
// Round-robin arbiter plus fixed-latency half-by-half multiplier shared by two pipelines.
// The grant is held from arbitration until the result pulse, or until the winner flushes.
module resource_arbiter_server #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    resource_arbiter_server_if.slave bus
);
    localparam int unsigned HalfW     = DATA_W / 2;
    localparam logic [3:0]  CountInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StBusy,
        StDone
    } state_e;

    state_e            state_q;
    logic              winner_q;       // 0: pipeline 1, 1: pipeline 2
    logic              last_served_q;  // same encoding as winner_q
    logic [3:0]        count_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] result_q;
    logic [1:0]        grant_q;
    logic [1:0]        result_valid_q;
    logic              busy_q;

    logic              pick;
    logic              winner_req;
    logic [DATA_W-1:0] winner_op;
    logic [DATA_W-1:0] op_lo;
    logic [DATA_W-1:0] op_hi;
    logic [DATA_W-1:0] product;

    always_comb begin
        // A lone requester wins; on a tie the one not served last wins.
        pick = bus.req_2;
        if (bus.req_1 && bus.req_2) begin
            pick = ~last_served_q;
        end
        winner_req = winner_q ? bus.req_2 : bus.req_1;
        winner_op  = winner_q ? bus.op_2  : bus.op_1;
        op_lo      = {{HalfW{1'b0}}, operand_q[HalfW-1:0]};
        op_hi      = {{HalfW{1'b0}}, operand_q[DATA_W-1:HalfW]};
        product    = op_lo * op_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            winner_q       <= 1'b0;
            last_served_q  <= 1'b1;
            count_q        <= '0;
            operand_q      <= '0;
            result_q       <= '0;
            grant_q        <= '0;
            result_valid_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_1 || bus.req_2) begin
                        winner_q <= pick;
                        grant_q  <= pick ? 2'b10 : 2'b01;
                        busy_q   <= 1'b1;
                        state_q  <= StGrant;
                    end
                end
                StGrant: begin
                    if (winner_req) begin
                        operand_q <= winner_op;
                        count_q   <= CountInit;
                        state_q   <= StBusy;
                    end else begin
                        grant_q       <= '0;
                        busy_q        <= 1'b0;
                        last_served_q <= winner_q;
                        state_q       <= StIdle;
                    end
                end
                StBusy: begin
                    // A flush wins over completion in the same cycle.
                    if (!winner_req) begin
                        grant_q       <= '0;
                        busy_q        <= 1'b0;
                        last_served_q <= winner_q;
                        state_q       <= StIdle;
                    end else if (count_q == '0) begin
                        result_q       <= product;
                        result_valid_q <= grant_q;
                        state_q        <= StDone;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                StDone: begin
                    grant_q        <= '0;
                    result_valid_q <= '0;
                    busy_q         <= 1'b0;
                    last_served_q  <= winner_q;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.grant_1      = grant_q[0];
    assign bus.grant_2      = grant_q[1];
    assign bus.stall_1      = bus.req_1 & ~grant_q[0];
    assign bus.stall_2      = bus.req_2 & ~grant_q[1];
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = busy_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (grant_q != 2'b11);
            assert ((result_valid_q & ~grant_q) == 2'b00);
        end
    end
`endif
endmodule
